// File: rtl/axi_pkg.sv
// Shared AXI widths, encodings and FSM state types for the slave memory.
package axi_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int LEN_W  = 4;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  // A burst is unsupported unless it is word-sized and FIXED or INCR.
  function automatic logic cfg_bad(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || !((burst == BURST_FIXED) || (burst == BURST_INCR));
  endfunction

endpackage

// File: rtl/axi_slave_mem_ram.sv
// DEPTH x 32 word RAM: one byte-enabled write port, one registered read port.
// A same-cycle read of the word being written returns the old contents.
module axi_slave_mem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_q;

    // One byte lane: strobed write, read register only loads when asked
    always_ff @(posedge clk) begin
      if (we && wstrb[gi]) lane_mem[waddr] <= wdata[gi*8 +: 8];
      if (re) lane_q <= lane_mem[raddr];
    end

    assign rdata[gi*8 +: 8] = lane_q;
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI slave memory: independent write (AW/W/B) and read (AR/R) engines over a
// byte-strobed word RAM. Unsupported size/burst or out-of-window beats answer SLVERR.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  input  logic              AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER,
  output logic              AWREADY,
  input  logic [ID_W-1:0]   WID,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BUSER,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  input  logic              ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [3:0]        RRESP,
  output logic              RLAST,
  output logic              RUSER,
  output logic              RVALID,
  input  logic              RREADY
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  // Window test on the byte offset so no slice depends on DEPTH.
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return {1'b0, off} < SPAN;
  endfunction

  logic unused_inputs;
  assign unused_inputs = ^{WID, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER,
                           ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER};

  // ---------------- write path ----------------
  wstate_e          w_state_reg, w_state_next;
  logic [ID_W-1:0]  w_id_reg, w_id_next;
  logic [31:0]      w_addr_reg, w_addr_next;
  logic [LEN_W-1:0] w_len_reg, w_len_next, w_beat_reg, w_beat_next;
  logic             w_incr_reg, w_incr_next, w_cfg_reg, w_cfg_next;
  logic             w_ovf_reg, w_ovf_next, w_err_reg, w_err_next;
  logic             awready_reg, wready_reg, bvalid_reg;
  logic             w_last, w_ok, w_carry, ram_we;
  logic [31:0]      w_sum;

  // Write FSM next state: a beat writes only if the burst config is legal and the
  // word lies inside the window; the beat count alone ends the burst.
  always_comb begin
    w_state_next = w_state_reg;
    w_id_next    = w_id_reg;
    w_addr_next  = w_addr_reg;
    w_len_next   = w_len_reg;
    w_beat_next  = w_beat_reg;
    w_incr_next  = w_incr_reg;
    w_cfg_next   = w_cfg_reg;
    w_ovf_next   = w_ovf_reg;
    w_err_next   = w_err_reg;
    w_last       = (w_beat_reg == w_len_reg);
    w_ok         = !w_cfg_reg && !w_ovf_reg && in_range(w_addr_reg);
    {w_carry, w_sum} = {1'b0, w_addr_reg} + 33'd4;
    ram_we       = 1'b0;
    case (w_state_reg)
      W_IDLE: if (AWVALID && awready_reg) begin
        w_id_next    = AWID;
        w_addr_next  = AWADDR;
        w_len_next   = AWLEN;
        w_incr_next  = (AWBURST == BURST_INCR);
        w_cfg_next   = cfg_bad(AWSIZE, AWBURST);
        w_ovf_next   = 1'b0;
        w_beat_next  = '0;
        w_err_next   = 1'b0;
        w_state_next = W_DATA;
      end
      W_DATA: if (WVALID && wready_reg) begin
        ram_we = w_ok;
        if (!w_ok || (WLAST != w_last)) w_err_next = 1'b1;
        if (w_incr_reg) begin
          w_addr_next = w_sum;
          w_ovf_next  = w_ovf_reg | w_carry;
        end
        w_beat_next = w_beat_reg + 4'd1;
        if (w_last) w_state_next = W_RESP;
      end
      W_RESP: if (BREADY && bvalid_reg) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // Write state register; handshake flags are registered so reset drives them low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      w_id_reg    <= '0;
      w_addr_reg  <= '0;
      w_len_reg   <= '0;
      w_beat_reg  <= '0;
      w_incr_reg  <= 1'b0;
      w_cfg_reg   <= 1'b0;
      w_ovf_reg   <= 1'b0;
      w_err_reg   <= 1'b0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      w_id_reg    <= w_id_next;
      w_addr_reg  <= w_addr_next;
      w_len_reg   <= w_len_next;
      w_beat_reg  <= w_beat_next;
      w_incr_reg  <= w_incr_next;
      w_cfg_reg   <= w_cfg_next;
      w_ovf_reg   <= w_ovf_next;
      w_err_reg   <= w_err_next;
      awready_reg <= (w_state_next == W_IDLE);
      wready_reg  <= (w_state_next == W_DATA);
      bvalid_reg  <= (w_state_next == W_RESP);
    end
  end

  assign AWREADY = awready_reg;
  assign WREADY  = wready_reg;
  assign BVALID  = bvalid_reg;
  assign BID     = w_id_reg;
  assign BRESP   = (bvalid_reg && w_err_reg) ? 2'(RESP_SLVERR) : 2'(RESP_OKAY);
  assign BUSER   = 1'b0;

  // ---------------- read path ----------------
  rstate_e          r_state_reg, r_state_next;
  logic [ID_W-1:0]  r_id_reg, r_id_next;
  logic [31:0]      r_addr_reg, r_addr_next, r_sum;
  logic [LEN_W-1:0] r_len_reg, r_len_next, r_beat_reg, r_beat_next;
  logic             r_incr_reg, r_incr_next, r_cfg_reg, r_cfg_next;
  logic             r_ovf_reg, r_ovf_next, rerr_reg, rerr_next, rlast_reg, rlast_next;
  logic             arready_reg, rvalid_reg, r_carry, ram_re;
  logic [31:0]      ram_rdata;

  // Read FSM next state: the RAM is only reloaded when a new beat is due,
  // so the presented beat stays frozen while the master stalls.
  always_comb begin
    r_state_next = r_state_reg;
    r_id_next    = r_id_reg;
    r_addr_next  = r_addr_reg;
    r_len_next   = r_len_reg;
    r_beat_next  = r_beat_reg;
    r_incr_next  = r_incr_reg;
    r_cfg_next   = r_cfg_reg;
    r_ovf_next   = r_ovf_reg;
    rerr_next    = rerr_reg;
    rlast_next   = rlast_reg;
    {r_carry, r_sum} = {1'b0, r_addr_reg} + 33'd4;
    ram_re       = 1'b0;
    case (r_state_reg)
      R_IDLE: if (ARVALID && arready_reg) begin
        r_id_next    = ARID;
        r_addr_next  = ARADDR;
        r_len_next   = ARLEN;
        r_incr_next  = (ARBURST == BURST_INCR);
        r_cfg_next   = cfg_bad(ARSIZE, ARBURST);
        r_ovf_next   = 1'b0;
        r_beat_next  = '0;
        rerr_next    = cfg_bad(ARSIZE, ARBURST) || !in_range(ARADDR);
        rlast_next   = (ARLEN == '0);
        ram_re       = 1'b1;
        r_state_next = R_DATA;
      end
      R_DATA: if (RREADY && rvalid_reg) begin
        if (r_beat_reg == r_len_reg) begin
          rerr_next    = 1'b0;
          rlast_next   = 1'b0;
          r_state_next = R_IDLE;
        end else begin
          if (r_incr_reg) begin
            r_addr_next = r_sum;
            r_ovf_next  = r_ovf_reg | r_carry;
          end
          r_beat_next = r_beat_reg + 4'd1;
          rlast_next  = ((r_beat_reg + 4'd1) == r_len_reg);
          rerr_next   = r_cfg_reg || r_ovf_next || !in_range(r_addr_next);
          ram_re      = 1'b1;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      r_id_reg    <= '0;
      r_addr_reg  <= '0;
      r_len_reg   <= '0;
      r_beat_reg  <= '0;
      r_incr_reg  <= 1'b0;
      r_cfg_reg   <= 1'b0;
      r_ovf_reg   <= 1'b0;
      rerr_reg    <= 1'b0;
      rlast_reg   <= 1'b0;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
    end else begin
      r_state_reg <= r_state_next;
      r_id_reg    <= r_id_next;
      r_addr_reg  <= r_addr_next;
      r_len_reg   <= r_len_next;
      r_beat_reg  <= r_beat_next;
      r_incr_reg  <= r_incr_next;
      r_cfg_reg   <= r_cfg_next;
      r_ovf_reg   <= r_ovf_next;
      rerr_reg    <= rerr_next;
      rlast_reg   <= rlast_next;
      arready_reg <= (r_state_next == R_IDLE);
      rvalid_reg  <= (r_state_next == R_DATA);
    end
  end

  assign ARREADY = arready_reg;
  assign RVALID  = rvalid_reg;
  assign RID     = r_id_reg;
  assign RLAST   = rlast_reg;
  assign RRESP   = {2'b00, rerr_reg ? 2'(RESP_SLVERR) : 2'(RESP_OKAY)};
  assign RDATA   = (rvalid_reg && !rerr_reg) ? ram_rdata : '0;
  assign RUSER   = 1'b0;

  axi_slave_mem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (w_addr_reg[AW+1:2]),
    .wdata (WDATA),
    .wstrb (WSTRB),
    .re    (ram_re),
    .raddr (r_addr_next[AW+1:2]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, strobes, backpressure, errors,
// read/write collision and mid-burst reset.
module tb_axi_slave_mem;

  localparam logic [1:0] FIX = 2'b00;
  localparam logic [1:0] INC = 2'b01;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  AWID, AWLEN, WID, BID, ARID, ARLEN, RID, RRESP;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BUSER, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RUSER, RVALID, RREADY;
  logic        AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER;
  logic        ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_data [16];
  logic [3:0]  exp_rresp [16];
  logic        bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  axi_slave_mem #(.DEPTH(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
    .AWQOS(AWQOS), .AWREGION(AWREGION), .AWUSER(AWUSER), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BUSER(BUSER), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .ARQOS(ARQOS), .ARREGION(ARREGION), .ARUSER(ARUSER), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RUSER(RUSER),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                       input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWID = id; AWVALID = 1'b1;
    while (!AWREADY && n < 50) begin tick(); n++; end
    check("awready", 32'(AWREADY), 32'd1);
    tick();
    AWVALID = 1'b0;
    $display("AW addr=0x%08h len=%0d size=%0d burst=%0d id=%0d", addr, len, size, burst, id);
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    while (!WREADY && n < 50) begin tick(); n++; end
    check("wready", 32'(WREADY), 32'd1);
    tick();
    WVALID = 1'b0;
    $display("W  data=0x%08h strb=0x%h last=%0d", data, strb, last);
  endtask

  task automatic get_b(input logic [1:0] resp, input logic [3:0] id, input string tag);
    int n = 0;
    BREADY = 1'b1;
    while (!BVALID && n < 50) begin tick(); n++; end
    check({tag, "_bvalid"}, 32'(BVALID), 32'd1);
    check({tag, "_bresp"}, 32'(BRESP), 32'(resp));
    check({tag, "_bid"}, 32'(BID), 32'(id));
    $display("B  %s resp=%0d id=%0d", tag, BRESP, BID);
    tick();
    BREADY = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                       input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARID = id; ARVALID = 1'b1;
    while (!ARREADY && n < 50) begin tick(); n++; end
    check("arready", 32'(ARREADY), 32'd1);
    tick();
    ARVALID = 1'b0;
    $display("AR addr=0x%08h len=%0d size=%0d burst=%0d id=%0d", addr, len, size, burst, id);
  endtask

  // Full read burst with RREADY held high, checked against exp_data/exp_rresp.
  task automatic read_burst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input string tag);
    do_ar(addr, len, size, burst, id);
    RREADY = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      int n = 0;
      while (!RVALID && n < 50) begin tick(); n++; end
      check({tag, "_rvalid"}, 32'(RVALID), 32'd1);
      check({tag, "_rdata"}, RDATA, exp_data[b]);
      check({tag, "_rresp"}, 32'(RRESP), 32'(exp_rresp[b]));
      check({tag, "_rlast"}, 32'(RLAST), 32'(b == int'(len)));
      check({tag, "_rid"}, 32'(RID), 32'(id));
      tick();
    end
    RREADY = 1'b0;
    check({tag, "_rvalid_end"}, 32'(RVALID), 32'd0);
    check({tag, "_arready_end"}, 32'(ARREADY), 32'd1);
    $display("R  %s %0d beats from 0x%08h", tag, int'(len) + 1, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat;
    int cyc;
    rst = 1'b1;
    {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID} = '0;
    {WID, WDATA, WSTRB, WLAST, WVALID, BREADY} = '0;
    {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY} = '0;
    {AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER} = '0;
    {ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER} = '0;
    repeat (3) tick();

    // Reset state
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_arready", 32'(ARREADY), 32'd0);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    rst = 1'b0;
    check("rel_awready", 32'(AWREADY), 32'd0);
    tick();
    check("post_awready", 32'(AWREADY), 32'd1);
    check("post_arready", 32'(ARREADY), 32'd1);

    // 4-beat INCR write then read back
    do_aw(32'h10, 4'd3, 3'd2, INC, 4'd5);
    for (int i = 0; i < 3; i++) do_w(32'hA0 + 32'(i), 4'hF, 1'b0);
    check("wr4_bvalid_early", 32'(BVALID), 32'd0);
    do_w(32'hA3, 4'hF, 1'b1);
    check("wr4_bvalid_1cyc", 32'(BVALID), 32'd1);
    get_b(2'b00, 4'd5, "wr4");
    for (int i = 0; i < 4; i++) begin exp_data[i] = 32'hA0 + 32'(i); exp_rresp[i] = 4'd0; end
    read_burst(32'h10, 4'd3, 3'd2, INC, 4'd9, "rd4");

    // Byte strobes
    do_aw(32'h20, 4'd0, 3'd2, INC, 4'd1);
    do_w(32'hFFFF_FFFF, 4'hF, 1'b1);
    get_b(2'b00, 4'd1, "strb_a");
    do_aw(32'h20, 4'd0, 3'd2, INC, 4'd2);
    do_w(32'h1122_3344, 4'h5, 1'b1);
    get_b(2'b00, 4'd2, "strb_b");
    exp_data[0] = 32'hFF22_FF44; exp_rresp[0] = 4'd0;
    read_burst(32'h20, 4'd0, 3'd2, INC, 4'd3, "strb");

    // Read backpressure: RREADY pattern 1,0,0,1 repeating
    do_ar(32'h10, 4'd3, 3'd2, INC, 4'd4);
    beat = 0;
    cyc  = 0;
    while (beat < 4 && cyc < 40) begin
      check("bp_rvalid", 32'(RVALID), 32'd1);
      check("bp_rdata", RDATA, 32'hA0 + 32'(beat));
      check("bp_rlast", 32'(RLAST), 32'(beat == 3));
      RREADY = bp_pat[cyc % 4];
      tick();
      if (RREADY) beat++;
      cyc++;
    end
    RREADY = 1'b0;
    check("bp_beats", 32'(beat), 32'd4);
    check("bp_cycles", 32'(cyc), 32'd8);
    check("bp_rvalid_end", 32'(RVALID), 32'd0);
    $display("R  backpressure read of 4 beats over %0d cycles", cyc);

    // Write response backpressure
    do_aw(32'h30, 4'd0, 3'd2, INC, 4'd6);
    do_w(32'h3333_3333, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bhold_bvalid", 32'(BVALID), 32'd1);
      check("bhold_awready", 32'(AWREADY), 32'd0);
      tick();
    end
    get_b(2'b00, 4'd6, "bhold");

    // Burst crossing the top of RAM: first word written, second rejected
    do_aw(32'hFFC, 4'd1, 3'd2, INC, 4'd7);
    do_w(32'h5555_AAAA, 4'hF, 1'b0);
    do_w(32'h1234_5678, 4'hF, 1'b1);
    get_b(2'b10, 4'd7, "top");
    exp_data[0] = 32'h5555_AAAA; exp_rresp[0] = 4'd0;
    exp_data[1] = 32'h0;         exp_rresp[1] = 4'b0010;
    read_burst(32'hFFC, 4'd1, 3'd2, INC, 4'd8, "top_rd");

    // Unsupported read size
    exp_data[0] = 32'h0; exp_rresp[0] = 4'b0010;
    exp_data[1] = 32'h0; exp_rresp[1] = 4'b0010;
    read_burst(32'h10, 4'd1, 3'd1, INC, 4'd2, "size_rd");

    // Early WLAST: all three beats still taken and written
    do_aw(32'h50, 4'd2, 3'd2, INC, 4'd3);
    do_w(32'h1, 4'hF, 1'b0);
    do_w(32'h2, 4'hF, 1'b1);
    do_w(32'h3, 4'hF, 1'b0);
    check("wlast_bvalid", 32'(BVALID), 32'd1);
    get_b(2'b10, 4'd3, "wlast");
    for (int i = 0; i < 3; i++) begin exp_data[i] = 32'(i + 1); exp_rresp[i] = 4'd0; end
    read_burst(32'h50, 4'd2, 3'd2, INC, 4'd3, "wlast_rd");

    // FIXED burst keeps hitting one word
    do_aw(32'h70, 4'd1, 3'd2, FIX, 4'd4);
    do_w(32'h7, 4'hF, 1'b0);
    do_w(32'h8, 4'hF, 1'b1);
    get_b(2'b00, 4'd4, "fixed");
    exp_data[0] = 32'h8; exp_rresp[0] = 4'd0;
    exp_data[1] = 32'h8; exp_rresp[1] = 4'd0;
    read_burst(32'h70, 4'd1, 3'd2, FIX, 4'd4, "fixed_rd");

    // Same-cycle write and read of word 0x40
    do_aw(32'h40, 4'd0, 3'd2, INC, 4'd1);
    do_w(32'hCAFE_0001, 4'hF, 1'b1);
    get_b(2'b00, 4'd1, "coll_pre");
    do_aw(32'h40, 4'd0, 3'd2, INC, 4'd2);
    WDATA = 32'hBEEF_0002; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    ARADDR = 32'h40; ARLEN = 4'd0; ARSIZE = 3'd2; ARBURST = INC; ARID = 4'd7; ARVALID = 1'b1;
    check("coll_wready", 32'(WREADY), 32'd1);
    check("coll_arready", 32'(ARREADY), 32'd1);
    tick();
    WVALID = 1'b0; ARVALID = 1'b0;
    check("coll_rvalid", 32'(RVALID), 32'd1);
    check("coll_rdata_old", RDATA, 32'hCAFE_0001);
    check("coll_rlast", 32'(RLAST), 32'd1);
    $display("RW collision at 0x40: read 0x%08h", RDATA);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    get_b(2'b00, 4'd2, "coll_b");
    exp_data[0] = 32'hBEEF_0002; exp_rresp[0] = 4'd0;
    read_burst(32'h40, 4'd0, 3'd2, INC, 4'd5, "coll_new");

    // Reset in the middle of a write burst
    do_aw(32'h60, 4'd3, 3'd2, INC, 4'd9);
    do_w(32'h61, 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_awready", 32'(AWREADY), 32'd0);
    check("mid_rst_wready", 32'(WREADY), 32'd0);
    check("mid_rst_bvalid", 32'(BVALID), 32'd0);
    check("mid_rst_arready", 32'(ARREADY), 32'd0);
    check("mid_rst_rvalid", 32'(RVALID), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    check("mid_rel_awready", 32'(AWREADY), 32'd0);
    tick();
    check("mid_post_awready", 32'(AWREADY), 32'd1);
    check("mid_post_wready", 32'(WREADY), 32'd0);
    tick();
    check("mid_post_bvalid", 32'(BVALID), 32'd0);
    $display("RST mid-burst recovered");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
Synthesizable AXI slave memory model that terminates the master-side bus driven by the UVM master agent. It acts as the DUT-side consumer behind the bus interface. It implements independent write (AW/W/B) and read (AR/R) paths over a byte-strobed word RAM. It serves as the reference responder the slave monitor and scoreboard check against.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, at least 2
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4-aligned

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
AWID in 4, AWADDR in 32, AWLEN in 4, AWSIZE in 3, AWBURST in 2, AWVALID in 1: write address channel
AWREADY  out  1  write address accept
WID in 4, WDATA in 32, WSTRB in 4, WLAST in 1, WVALID in 1: write data channel
WREADY  out  1  write data accept
BID out 4, BRESP out 2, BUSER out 1, BVALID out 1: write response; BREADY in 1
ARID in 4, ARADDR in 32, ARLEN in 4, ARSIZE in 3, ARBURST in 2, ARVALID in 1: read address channel
ARREADY  out  1  read address accept
RID out 4, RDATA out 32, RRESP out 4, RLAST out 1, RUSER out 1, RVALID out 1: read data; RREADY in 1
AW/AR LOCK, CACHE, PROT, QOS, REGION, USER  in  1 each  accepted and ignored

Behaviour:
- Reset (async assert, sync release): all outputs 0; both FSMs go to IDLE; RAM contents are not cleared.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
- W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch id, addr, len, size and burst; clear beat counter and error flag; next state W_DATA.
- W_DATA: WREADY=1 (cycle after the AW handshake). Each WVALID&WREADY beat writes the bytes enabled by WSTRB at the current word.
  - INCR advances the address by 4 per beat. FIXED holds the address.
  - After beat AWLEN (AWLEN+1 beats in total), go to W_RESP.
  - The beat counter alone terminates the burst.
  - WLAST mismatch (WLAST=1 before the final beat, or 0 on the final beat) sets the error flag. Data is still written.
- W_RESP: BVALID=1, BID=latched id, BRESP=OKAY(2'b00) or SLVERR(2'b10). Hold until BREADY. On handshake, return to W_IDLE; AWREADY=1 the following cycle.
- SLVERR conditions, checked per burst: size != 3'b010; burst = WRAP or reserved; any beat address outside [BASE_ADDR, BASE_ADDR+DEPTH*4). Out-of-range beats never write the RAM. The other two errors suppress all writes of that burst.
- WID is ignored; no interleaving. BUSER=0 and RUSER=0 always.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
- R_IDLE: ARREADY=1. On handshake, latch fields; next state R_DATA.
- R_DATA: beat 0 presents RVALID=1 the cycle after the AR handshake, with RDATA registered from the RAM.
  - On RVALID&RREADY, advance the address and load the next beat. RVALID stays high with no bubble.
  - RLAST=1 only on beat ARLEN.
  - After the last handshake, RVALID drops and ARREADY=1 the next cycle.
  - RVALID=1 && RREADY=0: RDATA, RID, RRESP and RLAST hold stable.
- Read errors use the same rules as writes. RRESP[1:0]=2'b10, RRESP[3:2]=0. RDATA=0 on erroring beats. RID=latched ARID.
- Address wrap: the INCR address counter is 32-bit. Crossing the top of RAM is an out-of-range error, not a wrap.
- Simultaneous write and read to the same word in the same cycle: the read returns the pre-write data; the write commits.
- The write and read paths are fully independent and may overlap every cycle.
- Reset asserted mid-burst: bursts are abandoned, outputs return to 0 immediately, and no B or R response is issued for them.

Decomposition:
- axi_pkg holds:
  - width constants: ID 4, ADDR 32, DATA 32, STRB 4, LEN 4.
  - resp encodings: OKAY, EXOKAY, SLVERR, DECERR.
  - burst encodings: FIXED, INCR, WRAP.
  - FSM state enums.
- One sub-module, axi_slave_mem_ram: DEPTH x 32 RAM with 1 write port (byte-enable) and 1 registered read port.

Test Plan:
- AW: AWADDR=0x10, AWLEN=3, INCR, size 2; 4 beats with WDATA=0xA0..0xA3 and WSTRB=0xF -> BRESP=0 with BID=AWID, exactly 1 cycle after the last beat. Then AR to the same address with ARLEN=3 -> RDATA=0xA0..0xA3, RLAST only on the 4th beat.
- Byte strobes: write 0xFFFFFFFF, then 0x11223344 with WSTRB=0x5, then read -> 0xFF22FF44.
- Backpressure: RREADY toggles 1,0,0,1 during a 4-beat read -> RDATA and RLAST are stable while stalled; no beat is lost or duplicated. BREADY held 0 for 5 cycles -> BVALID stays high and AWREADY stays 0.
- Errors:
  - AWADDR=BASE_ADDR+DEPTH*4-4 with AWLEN=1 -> BRESP=2'b10; the in-range word is written.
  - ARSIZE=3'b001 -> RRESP=4'b0010 on all beats, with RDATA=0.
- WLAST asserted on beat 1 of AWLEN=2 -> 3 beats are consumed, BRESP=SLVERR.
- Concurrent read and write to word 0x40 in the same cycle -> the read returns the old value and a later read returns the new value. Reset asserted mid-write-burst -> all outputs are 0 immediately, and AWREADY=1 one cycle after release.
